// File: rtl/rsp_s2_prep_ahbic_pkg.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_ahbic_pkg
// Shared encodings for the rsp_s2_prep AHB interconnect simple master:
//   - HTRANS / HRESP / HBURST encodings and the fixed HPROT value
//   - master FSM state encoding
// ----------------------------------------------------------------------------
package rsp_s2_prep_ahbic_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;
    localparam logic [1:0] HRESP_RETRY = 2'b10;
    localparam logic [1:0] HRESP_SPLIT = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    // Privileged data access, non-bufferable, non-cacheable.
    localparam logic [3:0] HPROT_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DATA,
        S_ERR,
        S_RTY,
        S_REISSUE
    } state_e;

endpackage

// File: rtl/rsp_s2_prep_ahbic_master_xfer_reg.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_ahbic_master_xfer_reg
// One {addr, write, size, wdata} transfer holding register with load enable.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset (clears to 0)
//   load_i               capture the *_i fields at the next clock edge
//   addr_i/write_i/size_i/wdata_i   transfer fields to capture
//   addr_o/write_o/size_o/wdata_o   held transfer fields
// ----------------------------------------------------------------------------
module rsp_s2_prep_ahbic_master_xfer_reg #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          load_i,
    input  logic [AW-1:0] addr_i,
    input  logic          write_i,
    input  logic [2:0]    size_i,
    input  logic [DW-1:0] wdata_i,
    output logic [AW-1:0] addr_o,
    output logic          write_o,
    output logic [2:0]    size_o,
    output logic [DW-1:0] wdata_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic          write_q, write_d;
    logic [2:0]    size_q, size_d;
    logic [DW-1:0] wdata_q, wdata_d;

    always_comb begin
        addr_d  = addr_q;
        write_d = write_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        if (load_i) begin
            addr_d  = addr_i;
            write_d = write_i;
            size_d  = size_i;
            wdata_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= 3'd0;
            wdata_q <= '0;
        end else begin
            addr_q  <= addr_d;
            write_q <= write_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
        end
    end

    assign addr_o  = addr_q;
    assign write_o = write_q;
    assign size_o  = size_q;
    assign wdata_o = wdata_q;

endmodule

// File: rtl/rsp_s2_prep_ahbic_simple_master.sv
// ----------------------------------------------------------------------------
// rsp_s2_prep_ahbic_simple_master
// AHB initiator: turns a valid/ready single-transfer command stream into
// pipelined NONSEQ/SINGLE transfers. Handles wait states and the two-cycle
// ERROR/RETRY/SPLIT responses; responses come back in command order.
// Ports:
//   HCLK, HRESETn                    clock, asynchronous active-low reset
//   cmd_valid/cmd_ready              command handshake
//   cmd_write/addr/size/wdata        command fields, sampled on acceptance
//   rsp_valid/rsp_err/rsp_rdata      one-cycle completion pulse, no backpressure
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA   AHB master outputs
//   HRDATA/HREADY/HRESP              AHB slave-side inputs
// Optional feature (macro RSP_S2_PREP_AHBM_ERRLOG_EN):
//   err_sticky/err_addr outputs, err_clr input: latches the address of the
//   first ERROR completion until cleared.
// ----------------------------------------------------------------------------
module rsp_s2_prep_ahbic_simple_master
    import rsp_s2_prep_ahbic_pkg::*;
#(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [2:0]    cmd_size,
    input  logic [DW-1:0] cmd_wdata,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata,
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
    output logic          err_sticky,
    output logic [AW-1:0] err_addr,
    input  logic          err_clr,
`endif
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic          HWRITE,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic [3:0]    HPROT,
    output logic          HMASTLOCK,
    output logic [DW-1:0] HWDATA,
    input  logic [DW-1:0] HRDATA,
    input  logic          HREADY,
    input  logic [1:0]    HRESP
);

    state_e        state_q, state_d;
    logic          ap_valid_q, ap_valid_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic          rsp_err_q, rsp_err_d;
    logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;

    logic [AW-1:0] ap_addr, dp_addr;
    logic          ap_write, dp_write;
    logic [2:0]    ap_size, dp_size;
    logic [DW-1:0] ap_wdata, dp_wdata;

    logic ap_phase, ap_adv, accept, done_ok, done_err;

    // New addresses may only go out while no ERROR/RETRY sequence is running.
    assign ap_phase  = (state_q == S_IDLE) || (state_q == S_DATA);
    assign ap_adv    = ap_valid_q & HREADY & ap_phase;
    assign cmd_ready = ~ap_valid_q | ap_adv;
    assign accept    = cmd_valid & cmd_ready;

    rsp_s2_prep_ahbic_master_xfer_reg #(.AW(AW), .DW(DW)) u_ap_reg (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .load_i  (accept),
        .addr_i  (cmd_addr),
        .write_i (cmd_write),
        .size_i  (cmd_size),
        .wdata_i (cmd_wdata),
        .addr_o  (ap_addr),
        .write_o (ap_write),
        .size_o  (ap_size),
        .wdata_o (ap_wdata)
    );

    rsp_s2_prep_ahbic_master_xfer_reg #(.AW(AW), .DW(DW)) u_dp_reg (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .load_i  (ap_adv),
        .addr_i  (ap_addr),
        .write_i (ap_write),
        .size_i  (ap_size),
        .wdata_i (ap_wdata),
        .addr_o  (dp_addr),
        .write_o (dp_write),
        .size_o  (dp_size),
        .wdata_o (dp_wdata)
    );

    // Address-phase bus drive: re-issue replays the data-phase transfer.
    always_comb begin
        HTRANS = HTRANS_IDLE;
        HADDR  = ap_addr;
        HWRITE = ap_write;
        HSIZE  = ap_size;
        if (state_q == S_REISSUE) begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = dp_addr;
            HWRITE = dp_write;
            HSIZE  = dp_size;
        end else if (ap_valid_q && ap_phase) begin
            HTRANS = HTRANS_NONSEQ;
        end
    end

    assign HWDATA    = dp_wdata;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DEFAULT;
    assign HMASTLOCK = 1'b0;

    always_comb begin
        state_d    = state_q;
        ap_valid_d = ap_valid_q;
        done_ok    = 1'b0;
        done_err   = 1'b0;

        // Accept wins over ap_adv: the slot is refilled on the same edge.
        if (accept) begin
            ap_valid_d = 1'b1;
        end else if (ap_adv) begin
            ap_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (ap_adv) state_d = S_DATA;
            end
            S_DATA: begin
                if (HREADY) begin
                    // HREADY high with a non-OKAY response is a slave protocol
                    // violation; report it as an error rather than dropping it.
                    if (HRESP == HRESP_OKAY) done_ok = 1'b1;
                    else                     done_err = 1'b1;
                    state_d = ap_adv ? S_DATA : S_IDLE;
                end else begin
                    unique case (HRESP)
                        HRESP_OKAY:                state_d = S_DATA;
                        HRESP_ERROR:               state_d = S_ERR;
                        HRESP_RETRY, HRESP_SPLIT:  state_d = S_RTY;
                    endcase
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    done_err = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_RTY: begin
                if (HREADY) state_d = S_REISSUE;
            end
            S_REISSUE: begin
                if (HREADY) state_d = S_DATA;
            end
            default: state_d = S_IDLE;
        endcase

        rsp_valid_d = done_ok | done_err;
        rsp_err_d   = done_err;
        rsp_rdata_d = (done_ok && !dp_write) ? HRDATA : '0;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= S_IDLE;
            ap_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            ap_valid_q  <= ap_valid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
    logic          err_sticky_q, err_sticky_d;
    logic [AW-1:0] err_addr_q, err_addr_d;

    // Only the first error is kept; clear has priority over a new error.
    always_comb begin
        err_sticky_d = err_sticky_q;
        err_addr_d   = err_addr_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
            err_addr_d   = '0;
        end else if (done_err && !err_sticky_q) begin
            err_sticky_d = 1'b1;
            err_addr_d   = dp_addr;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            err_sticky_q <= 1'b0;
            err_addr_q   <= '0;
        end else begin
            err_sticky_q <= err_sticky_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign err_sticky = err_sticky_q;
    assign err_addr   = err_addr_q;
`endif

endmodule

// File: tb/tb_rsp_s2_prep_ahbic_simple_master.sv
// ----------------------------------------------------------------------------
// tb_rsp_s2_prep_ahbic_simple_master
// Bench for the AHB simple master. A scripted AHB slave answers each address
// phase it samples; accepted commands and expected responses are kept in
// queues and compared against the bus and the response port.
// ----------------------------------------------------------------------------
module tb_rsp_s2_prep_ahbic_simple_master;
    import rsp_s2_prep_ahbic_pkg::*;

    logic        HCLK;
    logic        HRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS, HRESP;
    logic        HWRITE, HMASTLOCK, HREADY;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
    logic        err_sticky, err_clr;
    logic [31:0] err_addr;
`endif

    rsp_s2_prep_ahbic_simple_master #(.AW(32), .DW(32)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
        .err_sticky(err_sticky),
        .err_addr  (err_addr),
        .err_clr   (err_clr),
`endif
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    typedef struct { logic [1:0] resp; int unsigned waits; } script_t;
    typedef struct { logic write; logic [31:0] addr; logic [2:0] size; logic [31:0] wdata; } cmd_t;
    typedef struct { logic err; logic [31:0] rdata; } rsp_t;
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        int unsigned waits;
        logic [1:0]  resp;
        int unsigned exp_lat;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    script_t     script_q[$];
    cmd_t        cmd_q[$];
    rsp_t        exp_q[$];
    logic [31:0] addr_log[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    bit          rand_mode = 0;
    bit          rsp_due   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail(input string name);
        n_checks++;
        $display("FAIL %s: bound expired at %0t", name, $time);
    endtask

    function automatic logic [31:0] slv_data(input logic [31:0] a);
        logic [15:0] lo;
        lo = a[15:0];
        return (a == 32'h100) ? 32'hCAFE_F00D : {~lo, lo};
    endfunction

    function automatic script_t rand_script();
        script_t s;
        int unsigned r;
        s.waits = $urandom_range(0, 2);
        r = $urandom_range(0, 99);
        if (r < 80)      s.resp = HRESP_OKAY;
        else if (r < 88) s.resp = HRESP_ERROR;
        else if (r < 94) s.resp = HRESP_RETRY;
        else             s.resp = HRESP_SPLIT;
        return s;
    endfunction

    // Bus values sampled mid-cycle, used by the slave at the following edge.
    logic [1:0]  n_htrans;
    logic [31:0] n_haddr, n_hwdata;
    logic        n_hwrite;
    logic [2:0]  n_hsize;
    initial forever begin
        @(negedge HCLK);
        n_htrans = HTRANS;
        n_haddr  = HADDR;
        n_hwrite = HWRITE;
        n_hsize  = HSIZE;
        n_hwdata = HWDATA;
    end

    // Scripted AHB slave and transfer scoreboard.
    initial begin : slave
        bit          in_dp;
        bit          ph2;
        cmd_t        dp;
        cmd_t        c;
        script_t     s;
        int unsigned w_left;
        logic [1:0]  slv_resp;
        in_dp = 0; ph2 = 0; w_left = 0; slv_resp = HRESP_OKAY;
        dp = '{1'b0, 32'h0, 3'd0, 32'h0};
        HREADY = 1'b1; HRESP = HRESP_OKAY; HRDATA = 32'h0;
        forever begin
            @(posedge HCLK);
            rsp_due = 0;
            if (!HRESETn) begin
                in_dp = 0;
            end else begin
                if (in_dp && HREADY) begin
                    in_dp = 0;
                    if (slv_resp == HRESP_OKAY || slv_resp == HRESP_ERROR) begin
                        if (cmd_q.size() == 0) begin
                            fail("xfer_without_cmd");
                        end else begin
                            c = cmd_q.pop_front();
                            chk("xfer_addr", dp.addr, c.addr);
                            chk("xfer_write", dp.write, c.write);
                            chk("xfer_size", dp.size, c.size);
                            if (slv_resp == HRESP_OKAY && c.write) chk("hwdata", n_hwdata, c.wdata);
                            exp_q.push_back('{slv_resp == HRESP_ERROR,
                                (slv_resp == HRESP_OKAY && !c.write) ? slv_data(c.addr) : 32'h0});
                            rsp_due = 1;
                        end
                    end
                end else if (in_dp) begin
                    if (w_left > 0) w_left--;
                    else            ph2 = 1;
                end
                if (HREADY && n_htrans == HTRANS_NONSEQ) begin
                    in_dp = 1;
                    ph2   = 0;
                    dp    = '{n_hwrite, n_haddr, n_hsize, 32'h0};
                    addr_log.push_back(n_haddr);
                    if (script_q.size() > 0) s = script_q.pop_front();
                    else if (rand_mode)      s = rand_script();
                    else                     s = '{HRESP_OKAY, 0};
                    w_left   = s.waits;
                    slv_resp = s.resp;
                end
            end
            #1;
            HRDATA = $urandom;
            if (!in_dp) begin
                HREADY = 1'b1; HRESP = HRESP_OKAY;
            end else if (w_left > 0) begin
                HREADY = 1'b0; HRESP = HRESP_OKAY;
            end else if (slv_resp == HRESP_OKAY) begin
                HREADY = 1'b1; HRESP = HRESP_OKAY;
                if (!dp.write) HRDATA = slv_data(dp.addr);
            end else begin
                HREADY = ph2; HRESP = slv_resp;
            end
        end
    end

    // Response checker: exactly one rsp_valid the cycle after each completion.
    initial forever begin : rsp_chk
        rsp_t r;
        @(negedge HCLK);
        if (HRESETn && (rsp_due || rsp_valid)) begin
            chk("rsp_valid", rsp_valid, rsp_due);
            if (rsp_due) begin
                if (exp_q.size() == 0) begin
                    fail("rsp_exp_empty");
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_err", rsp_err, r.err);
                    chk("rsp_rdata", rsp_rdata, r.rdata);
                end
            end
        end
    end

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_size  = 3'($urandom);
        cmd_wdata = $urandom;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd);
        int unsigned t;
        t = 0;
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = sz; cmd_wdata = wd;
        @(negedge HCLK);
        while (!cmd_ready && t < 200) begin
            @(negedge HCLK);
            t++;
        end
        if (!cmd_ready) begin
            fail("cmd_ready_wait");
            idle();
            @(posedge HCLK);
            #1;
        end else begin
            @(posedge HCLK);
            cmd_q.push_back('{w, a, sz, wd});
            #1;
        end
    endtask

    task automatic drain();
        int unsigned t;
        t = 0;
        idle();
        while ((cmd_q.size() > 0 || exp_q.size() > 0 || rsp_due) && t < 1000) begin
            @(posedge HCLK);
            t++;
        end
        repeat (2) @(posedge HCLK);
        #1;
        if (cmd_q.size() > 0 || exp_q.size() > 0) fail("drain");
    endtask

    vec_t vt[7];

    initial begin : main
        int unsigned lat;
        bit          got;
        logic        g_err;
        logic [31:0] g_rdata, a;
        logic [2:0]  sz;

        vt[0] = '{1'b0, 32'h100, 3'd2, 32'h0,         0, HRESP_OKAY,  2, 1'b0, 32'hCAFE_F00D};
        vt[1] = '{1'b1, 32'h8,   3'd2, 32'h1234_5678, 3, HRESP_OKAY,  5, 1'b0, 32'h0};
        vt[2] = '{1'b0, 32'h40,  3'd1, 32'h0,         1, HRESP_OKAY,  3, 1'b0, 32'hFFBF_0040};
        vt[3] = '{1'b1, 32'h44,  3'd0, 32'hDEAD_BEEF, 0, HRESP_ERROR, 3, 1'b1, 32'h0};
        vt[4] = '{1'b0, 32'h48,  3'd2, 32'h0,         2, HRESP_ERROR, 5, 1'b1, 32'h0};
        vt[5] = '{1'b0, 32'h20,  3'd2, 32'h0,         0, HRESP_RETRY, 5, 1'b0, 32'hFFDF_0020};
        vt[6] = '{1'b1, 32'h50,  3'd2, 32'h0BAD_F00D, 1, HRESP_SPLIT, 6, 1'b0, 32'h0};

        HRESETn = 1'b0;
        idle();
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
        err_clr = 1'b0;
`endif
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_htrans", HTRANS, HTRANS_IDLE);
        chk("rst_haddr", HADDR, 32'h0);
        chk("rst_hwrite", HWRITE, 1'b0);
        chk("rst_hsize", HSIZE, 3'd0);
        chk("rst_hwdata", HWDATA, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("hburst", HBURST, 3'b000);
        chk("hprot", HPROT, 4'b0011);
        chk("hmastlock", HMASTLOCK, 1'b0);
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
        chk("rst_err_sticky", err_sticky, 1'b0);
        chk("rst_err_addr", err_addr, 32'h0);
`endif
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(posedge HCLK);
        #1;

        // Isolated single transfers: latency and response fields.
        foreach (vt[i]) begin
            script_q.push_back('{vt[i].resp, vt[i].waits});
            send(vt[i].write, vt[i].addr, vt[i].size, vt[i].wdata);
            idle();
            lat = 0; got = 0; g_err = 1'b0; g_rdata = 32'h0;
            while (!got && lat < 50) begin
                @(posedge HCLK);
                lat++;
                @(negedge HCLK);
                got = rsp_valid;
                g_err = rsp_err;
                g_rdata = rsp_rdata;
            end
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(vt[i].exp_lat));
            chk($sformatf("vec%0d_err", i), g_err, vt[i].exp_err);
            chk($sformatf("vec%0d_rdata", i), g_rdata, vt[i].exp_rdata);
            drain();
        end

        // Single read: one NONSEQ cycle, then IDLE.
        send(1'b0, 32'h100, 3'd2, 32'h0);
        idle();
        @(negedge HCLK);
        chk("rd100_htrans_nonseq", HTRANS, HTRANS_NONSEQ);
        chk("rd100_haddr", HADDR, 32'h100);
        chk("rd100_hwrite", HWRITE, 1'b0);
        @(negedge HCLK);
        chk("rd100_htrans_idle", HTRANS, HTRANS_IDLE);
        drain();

        // Back-to-back writes: address of 0x4 overlaps data phase of 0x0.
        send(1'b1, 32'h0, 3'd2, 32'hA0A0_0001);
        send(1'b1, 32'h4, 3'd2, 32'hB0B0_0002);
        idle();
        @(negedge HCLK);
        chk("b2b_htrans", HTRANS, HTRANS_NONSEQ);
        chk("b2b_haddr", HADDR, 32'h4);
        chk("b2b_hwdata0", HWDATA, 32'hA0A0_0001);
        @(negedge HCLK);
        chk("b2b_hwdata1", HWDATA, 32'hB0B0_0002);
        chk("b2b_htrans_idle", HTRANS, HTRANS_IDLE);
        drain();

        // Wait states: HADDR/HWDATA held while HREADY is low.
        script_q.push_back('{HRESP_OKAY, 3});
        send(1'b1, 32'h8, 3'd2, 32'h5555_AAAA);
        idle();
        @(negedge HCLK);
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            chk("ws_haddr", HADDR, 32'h8);
            chk("ws_hwdata", HWDATA, 32'h5555_AAAA);
        end
        drain();

        // ERROR on 0x10 with 0x14 pipelined.
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
        err_clr = 1'b1;
        @(posedge HCLK);
        #1;
        err_clr = 1'b0;
`endif
        addr_log.delete();
        script_q.push_back('{HRESP_ERROR, 0});
        script_q.push_back('{HRESP_OKAY, 0});
        send(1'b0, 32'h10, 3'd2, 32'h0);
        send(1'b0, 32'h14, 3'd2, 32'h0);
        idle();
        @(negedge HCLK);
        @(negedge HCLK);
        chk("err_htrans_idle", HTRANS, HTRANS_IDLE);
        drain();
        chk("err_log_n", 64'(addr_log.size()), 64'd2);
        if (addr_log.size() == 2) chk("err_reissue_addr", addr_log[1], 32'h14);
`ifdef RSP_S2_PREP_AHBM_ERRLOG_EN
        chk("errlog_sticky", err_sticky, 1'b1);
        chk("errlog_addr", err_addr, 32'h10);
        err_clr = 1'b1;
        @(posedge HCLK);
        #1;
        err_clr = 1'b0;
        @(negedge HCLK);
        chk("errlog_clr_sticky", err_sticky, 1'b0);
        chk("errlog_clr_addr", err_addr, 32'h0);
        @(posedge HCLK);
        #1;
`endif

        // RETRY on 0x20 with 0x24 pipelined: 0x20 re-issued first.
        addr_log.delete();
        script_q.push_back('{HRESP_RETRY, 0});
        script_q.push_back('{HRESP_OKAY, 0});
        script_q.push_back('{HRESP_OKAY, 0});
        send(1'b0, 32'h20, 3'd2, 32'h0);
        send(1'b0, 32'h24, 3'd2, 32'h0);
        drain();
        chk("rty_log_n", 64'(addr_log.size()), 64'd3);
        if (addr_log.size() == 3) begin
            chk("rty_addr0", addr_log[0], 32'h20);
            chk("rty_addr1", addr_log[1], 32'h20);
            chk("rty_addr2", addr_log[2], 32'h24);
        end

        // Reset during a wait state.
        script_q.push_back('{HRESP_OKAY, 5});
        send(1'b0, 32'h30, 3'd2, 32'h0);
        idle();
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b0;
        #1;
        chk("mrst_htrans", HTRANS, HTRANS_IDLE);
        chk("mrst_haddr", HADDR, 32'h0);
        chk("mrst_rsp_valid", rsp_valid, 1'b0);
        cmd_q.delete();
        exp_q.delete();
        script_q.delete();
        repeat (3) @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            chk("mrst_no_rsp", rsp_valid, 1'b0);
        end
        chk("mrst_cmd_ready", cmd_ready, 1'b1);
        @(posedge HCLK);
        #1;

        // Randomized traffic against the scripted slave and scoreboard.
        rand_mode = 1;
        for (int i = 0; i < 300; i++) begin
            sz = 3'($urandom_range(0, 2));
            a  = $urandom;
            a  = a & ~((32'd1 << sz) - 32'd1);
            send(1'($urandom), a, sz, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                idle();
                repeat ($urandom_range(1, 3)) @(posedge HCLK);
                #1;
            end
        end
        drain();
        rand_mode = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
